// File: rtl/sevenseg_ext_scanner.sv
// Multiplexed seven-segment scan driver producing {blank, dp, dash, nibble} codes and active-low anodes.
// Optional brightness control (duty input) enabled by defining SEVENSEG_SCAN_BRIGHT_EN.
module sevenseg_ext_scanner #(
    parameter int NDIGITS   = 8,
    parameter int DIV_COUNT = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic [NDIGITS-1:0]     dp_mask,
    input  logic [NDIGITS-1:0]     dash_mask,
    input  logic                   blank_lz,
`ifdef SEVENSEG_SCAN_BRIGHT_EN
    input  logic [3:0]             duty,
`endif
    output logic [6:0]             d_ext,
    output logic [NDIGITS-1:0]     an_n,
    output logic                   frame_done
);

    localparam int PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [6:0] BLANK_CODE = 7'b1000000;

    logic [4*NDIGITS-1:0] shadow_value;
    logic [NDIGITS-1:0]   shadow_dp;
    logic [NDIGITS-1:0]   shadow_dash;
    logic [PW-1:0]        prescaler;
    logic [IW-1:0]        idx;
    logic [IW-1:0]        next_idx;
    logic [NDIGITS-1:0]   an_q;
    logic [6:0]           d_q;
    logic [6:0]           next_code;
    logic [3:0]           sel_nibble;
    logic                 upper_zero;
    logic                 tick;

    assign tick = enable && (prescaler == PW'(DIV_COUNT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            shadow_dash  <= '0;
        end else if (load) begin
            shadow_value <= value;
            shadow_dp    <= dp_mask;
            shadow_dash  <= dash_mask;
        end
    end

    // Code for the digit about to be selected, built from the shadow frame as it stands before this edge.
    always_comb begin
        next_idx   = (idx == IW'(NDIGITS - 1)) ? '0 : idx + IW'(1);
        upper_zero = 1'b1;
        sel_nibble = '0;
        for (int j = 0; j < NDIGITS; j++) begin
            if (j >= int'(next_idx)) begin
                if (shadow_value[4*j +: 4] != 4'd0 || shadow_dash[j]) begin
                    upper_zero = 1'b0;
                end
            end
            if (IW'(j) == next_idx) begin
                sel_nibble = shadow_value[4*j +: 4];
            end
        end
        if (blank_lz && next_idx != '0 && upper_zero) begin
            next_code = BLANK_CODE;
        end else begin
            next_code = {1'b0, shadow_dp[next_idx], shadow_dash[next_idx], sel_nibble};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler  <= '0;
            idx        <= IW'(NDIGITS - 1);
            an_q       <= '1;
            d_q        <= BLANK_CODE;
            frame_done <= 1'b0;
        end else if (!enable) begin
            prescaler  <= '0;
            idx        <= IW'(NDIGITS - 1);
            an_q       <= '1;
            d_q        <= BLANK_CODE;
            frame_done <= 1'b0;
        end else if (tick) begin
            prescaler  <= '0;
            idx        <= next_idx;
            an_q       <= ~(NDIGITS'(1) << next_idx);
            d_q        <= next_code;
            frame_done <= (next_idx == '0);
        end else begin
            prescaler  <= prescaler + PW'(1);
            frame_done <= 1'b0;
        end
    end

`ifdef SEVENSEG_SCAN_BRIGHT_EN
    logic lit_q;

    // Registered on-window so the dark portion begins the cycle after the compare fails.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lit_q <= 1'b0;
        end else if (!enable) begin
            lit_q <= 1'b0;
        end else begin
            lit_q <= (32'(prescaler) * 32'd16) < (32'(DIV_COUNT) * 32'(duty));
        end
    end

    assign an_n  = lit_q ? an_q : '1;
    assign d_ext = lit_q ? d_q : BLANK_CODE;
`else
    assign an_n  = an_q;
    assign d_ext = d_q;
`endif

endmodule

// File: doc/sevenseg_ext_scanner.md
Name: sevenseg_ext_scanner

Overview:
Time-multiplexed scan driver that produces the 7-bit extended digit code {blank, dp, dash, nibble[3:0]} consumed by the seven-segment decoder. It also drives one-hot active-low anodes for an NDIGITS display.
- Latches a full frame: 32-bit hex value plus per-digit dp and dash masks.
- Cycles through the digits at a programmable rate.
- Applies optional leading-zero blanking.
- Sits between lab datapath outputs and the decoder/board pins.

Parameters:
NDIGITS, 8, number of display digits (2..8); value width is 4*NDIGITS.
DIV_COUNT, 100000, clock cycles per digit slot (>=2); 1 kHz digit rate at 100 MHz.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  scanning enable; low = display dark
load  input  1  single-cycle strobe; captures value/dp_mask/dash_mask into shadow regs
value  input  4*NDIGITS  hex nibbles; nibble i shown on digit i (digit 0 = rightmost)
dp_mask  input  NDIGITS  1 = decimal point lit on digit i
dash_mask  input  NDIGITS  1 = digit i shows a dash instead of its nibble
blank_lz  input  1  1 = blank leading zero digits
d_ext  output  7  {blank, dp, dash, nibble} to the decoder d input
an_n  output  NDIGITS  active-low one-hot anode select
frame_done  output  1  one-cycle pulse when scan returns to digit 0

Behaviour:
- Reset (async, rst=1):
  - shadow value, dp and dash registers = 0.
  - prescaler = 0, idx = NDIGITS-1.
  - an_n = all 1s, d_ext = 7'b1000000, frame_done = 0.
- Load: on any edge with load=1, the shadow registers take the inputs.
  - Displayed outputs change only at the next digit tick; no mid-slot change.
- Prescaler: counts 0..DIV_COUNT-1 while enable=1; tick = (prescaler == DIV_COUNT-1); prescaler wraps to 0 on tick.
- On tick (single edge, all registered together):
  - idx <= (idx == NDIGITS-1) ? 0 : idx+1.
  - an_n <= ~(1 << new idx).
  - d_ext <= code for new idx.
  - frame_done <= 1 iff new idx == 0; otherwise frame_done <= 0.
- Between ticks: an_n and d_ext hold; frame_done = 0.
- Digit code for digit i, highest priority first:
  - Leading-zero blank: blank_lz=1, i>0, shadow nibbles i..NDIGITS-1 all 0, and dash bits i..NDIGITS-1 all 0 -> 7'b1000000. dp is suppressed.
  - Dash bit set -> {0, dp[i], 1, nibble[i]}.
  - Otherwise -> {0, dp[i], 0, nibble[i]}.
  - Digit 0 is never blanked, so value 0 shows "0".
- Enable low:
  - Synchronously forces prescaler = 0, idx = NDIGITS-1, an_n = all 1s, d_ext = 7'b1000000, frame_done = 0.
  - After enable returns high, the first tick (DIV_COUNT cycles later) selects digit 0 with frame_done=1.
- load and tick in the same cycle: the code is computed from the old shadow; the new data appears at the following tick.
- Reset mid-scan: immediate return to reset values regardless of clk.

Optional Feature:
Macro SEVENSEG_SCAN_BRIGHT_EN.
- Defined:
  - Adds input port duty [3:0].
  - Within each slot, the anode is asserted only while prescaler*16 < DIV_COUNT*duty.
  - Outside that window: an_n = all 1s and d_ext = 7'b1000000.
  - Window edges are registered, so the off portion starts one cycle after the compare.
  - duty=0 -> always dark; duty is sampled every cycle.
- Undefined: no duty port; full duty as in Behaviour.

Test Plan:
1. Reset: rst=1 mid-scan -> an_n=8'hFF, d_ext=7'h40, frame_done=0 immediately; after release with enable=1 and DIV_COUNT=4, digit 0 is selected at cycle 4 with frame_done=1.
2. Scan order: load value=32'h1234ABCD, dp_mask=0, DIV_COUNT=4 -> an_n sequence FE,FD,FB,...,7F; d_ext 0D,0C,0B,0A,04,03,02,01; wraps to FE with frame_done pulse.
3. Leading-zero blanking: value=32'h00000050, blank_lz=1 -> digits 0,1 = 00,05; digits 2..7 = 40. With blank_lz=0, digits 2..7 = 00.
4. Masks: dp_mask=8'h02, dash_mask=8'h80, value=0, blank_lz=1 -> digit 7 = 10 (dash stops blanking); digits 1..6 = 00, but digit 1 = 20; digit 0 = 00.
5. Load timing: load asserted in the cycle of a tick -> that slot shows old data; new data appears on the next slot. enable=0 for 3 cycles -> an_n=FF, then restart at digit 0.
6. With SEVENSEG_SCAN_BRIGHT_EN, DIV_COUNT=16, duty=4 -> each digit is lit for 4 of 16 cycles; duty=0 -> an_n stays FF.
